// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_NOT  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_EQ   = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_RSV0 = 4'b1100;
   localparam logic [3:0] OP_RSV1 = 4'b1101;
   localparam logic [3:0] OP_RSV2 = 4'b1110;
   localparam logic [3:0] OP_RSV3 = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_seq_adder.sv
// N-bit ripple adder with carry-in, giving sum, carry-out, zero and signed overflow.
module alu_seq_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_s,
   output logic         o_c,
   output logic         o_z,
   output logic         o_v
);

   logic [N:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
   assign o_s   = w_sum[N-1:0];
   assign o_c   = w_sum[N];
   assign o_z   = (w_sum[N-1:0] == {N{1'b0}});
   // Overflow: operands share a sign that the sum does not.
   assign o_v   = (i_a[N-1] == i_b[N-1]) & (w_sum[N-1] != i_a[N-1]);

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes; single-cycle ops take one
// clock, unsigned multiply iterates shift-add over WIDTH clocks.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_c,
   output logic             zero,
   output logic             overflow
);

   localparam int          AW       = 2 * WIDTH;
   localparam logic [5:0]  CNT_INIT = 6'(WIDTH);
   localparam logic [31:0] WIDTH_L  = 32'(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_mul_last;
   logic [WIDTH-1:0] w_add_b;
   logic [WIDTH-1:0] w_add_s;
   logic             w_add_c;
   logic             w_add_z;
   logic             w_add_v;
   logic [31:0]      w_amt;
   logic             w_big;
   logic [WIDTH-1:0] w_res_s;
   logic             w_res_c;
   logic             w_res_v;
   logic [AW-1:0]    r_mcand;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    w_acc_nxt;
   logic [WIDTH-1:0] r_mplier;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_out_s;
   logic             r_out_c;
   logic             r_zero;
   logic             r_ovf;

   assign w_accept   = in_valid & (r_state == ST_IDLE);
   assign w_mul_last = (r_state == ST_MUL) & (r_cnt == 6'd1);

   // Every opcode except ADD runs the adder as a subtractor (x + ~y + 1).
   assign w_add_b = (op == OP_ADD) ? in_y : ~in_y;

   alu_seq_adder #(.N(WIDTH)) u_adder (
      .i_a   (in_x),
      .i_b   (w_add_b),
      .i_cin (op != OP_ADD),
      .o_s   (w_add_s),
      .o_c   (w_add_c),
      .o_z   (w_add_z),
      .o_v   (w_add_v)
   );

   assign w_amt     = 32'(in_y);
   assign w_big     = (w_amt >= WIDTH_L);
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   // Single-cycle result and flags for the current operands.
   always_comb begin
      w_res_s = {WIDTH{1'b0}};
      w_res_c = 1'b0;
      w_res_v = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            w_res_s = w_add_s;
            w_res_c = w_add_c;
            w_res_v = w_add_v;
         end
         OP_NOT: w_res_s = ~in_x;
         OP_AND: w_res_s = in_x & in_y;
         OP_OR:  w_res_s = in_x | in_y;
         OP_XOR: w_res_s = in_x ^ in_y;
         OP_SLT: begin
            w_res_s = {{(WIDTH-1){1'b0}}, w_add_s[WIDTH-1] ^ w_add_v};
            w_res_c = w_add_c;
            w_res_v = w_add_v;
         end
         OP_EQ: begin
            w_res_s = {{(WIDTH-1){1'b0}}, w_add_z};
            w_res_c = w_add_c;
            w_res_v = w_add_v;
         end
         OP_SLL: begin
            if (w_big) w_res_s = {WIDTH{1'b0}};
            else       w_res_s = in_x << w_amt;
         end
         OP_SRL: begin
            if (w_big) w_res_s = {WIDTH{1'b0}};
            else       w_res_s = in_x >> w_amt;
         end
         OP_SRA: begin
            if (w_big) w_res_s = {WIDTH{in_x[WIDTH-1]}};
            else       w_res_s = $unsigned($signed(in_x) >>> w_amt);
         end
         OP_MUL, OP_RSV0, OP_RSV1, OP_RSV2, OP_RSV3: begin
            w_res_s = {WIDTH{1'b0}};
         end
         default: w_res_s = {WIDTH{1'b0}};
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; a drain edge never doubles as an accept edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (op == OP_MUL) w_state_nxt = ST_MUL;
               else              w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (r_cnt == 6'd1) w_state_nxt = ST_DONE;
            else               w_state_nxt = ST_MUL;
         end
         ST_DONE: begin
            if (out_ready) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Multiplier datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= {AW{1'b0}};
         r_acc    <= {AW{1'b0}};
         r_mplier <= {WIDTH{1'b0}};
         r_cnt    <= 6'd0;
         r_out_s  <= {WIDTH{1'b0}};
         r_out_c  <= 1'b0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         if (op == OP_MUL) begin
            r_mcand  <= {{WIDTH{1'b0}}, in_x};
            r_mplier <= in_y;
            r_acc    <= {AW{1'b0}};
            r_cnt    <= CNT_INIT;
         end else begin
            r_out_s <= w_res_s;
            r_out_c <= w_res_c;
            r_zero  <= (w_res_s == {WIDTH{1'b0}});
            r_ovf   <= w_res_v;
         end
      end else if (r_state == ST_MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1'b1;
         r_mplier <= r_mplier >> 1'b1;
         r_cnt    <= r_cnt - 6'd1;
         if (w_mul_last) begin
            r_out_s <= w_acc_nxt[WIDTH-1:0];
            r_out_c <= |w_acc_nxt[AW-1:WIDTH];
            r_zero  <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
            r_ovf   <= 1'b0;
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_s     = r_out_s;
   assign out_c     = r_out_c;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq (WIDTH=8) plus backpressure and reset-abort sequences.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_s;
   logic         out_c;
   logic         zero;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] s;
      logic         c;
      logic         z;
      logic         v;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_c     (out_c),
      .zero      (zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] s, input logic c, input logic z, input logic v,
                      input int lat);
      vec_t t;
      t.op = o; t.x = x; t.y = y; t.s = s; t.c = c; t.z = z; t.v = v; t.lat = lat;
      vecs.push_back(t);
   endtask

   // Present one op for exactly one accepting edge, then count edges until out_valid.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int n);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; in_x = x; in_y = y;
      @(negedge clk);
      in_valid = 1'b0; op = 4'hE; in_x = 8'h00; in_y = 8'h00;
      n = 0;
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Drain the result while offering a new op that must not be taken on the same edge.
   task automatic drain(input string name);
      out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; in_x = 8'h01; in_y = 8'h01;
      @(negedge clk);
      chk({name, "_drain_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_drain_ready"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; in_x = 8'h00; in_y = 8'h00;

      //   op       x      y      s      c     z     v     lat
      add(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0);
      add(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0);
      add(OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 0);
      add(OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
      add(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
      add(OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
      add(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0);
      add(OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
      add(OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_SLT, 8'hFE, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 0);
      add(OP_SLT, 8'h01, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_SLT, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 0);
      add(OP_EQ,  8'h5A, 8'h5A, 8'h01, 1'b1, 1'b0, 1'b0, 0);
      add(OP_EQ,  8'h5A, 8'h5B, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_SLL, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 0);
      add(OP_SLL, 8'h81, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_SRL, 8'h90, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_SRL, 8'h90, 8'h04, 8'h09, 1'b0, 1'b0, 1'b0, 0);
      add(OP_SRA, 8'h90, 8'h02, 8'hE4, 1'b0, 1'b0, 1'b0, 0);
      add(OP_SRA, 8'h90, 8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
      add(OP_SRA, 8'h70, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_RSV0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_RSV3, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0, W);
      add(OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b0, W);
      add(OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, W);
      add(OP_MUL, 8'h00, 8'hAB, 8'h00, 1'b0, 1'b1, 1'b0, W);

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'h0);
      chk("rst_out_c", 32'(out_c), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].x, vecs[i].y, n);
         chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_out_s", i), 32'(out_s), 32'(vecs[i].s));
         chk($sformatf("v%0d_out_c", i), 32'(out_c), 32'(vecs[i].c));
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
         chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].v));
         drain($sformatf("v%0d", i));
      end

      // Backpressure: result held, new requests ignored while the consumer stalls.
      issue(OP_ADD, 8'h03, 8'h04, n);
      chk("bp_latency", 32'(n), 32'd0);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; op = OP_SUB; in_x = 8'hFF; in_y = 8'h01;
         @(negedge clk);
         chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d_out_s", k), 32'(out_s), 32'h07);
         chk($sformatf("bp%0d_out_c", k), 32'(out_c), 32'd0);
      end
      drain("bp");

      // Reset in the middle of a multiply aborts it.
      @(negedge clk);
      in_valid = 1'b1; op = OP_MUL; in_x = 8'h0F; in_y = 8'h0F;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("mid_mul_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_s", 32'(out_s), 32'h0);
      chk("abort_zero", 32'(zero), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      issue(OP_ADD, 8'h03, 8'h04, n);
      chk("post_abort_latency", 32'(n), 32'd0);
      chk("post_abort_out_s", 32'(out_s), 32'h07);
      chk("post_abort_out_c", 32'(out_c), 32'd0);
      chk("post_abort_zero", 32'(zero), 32'd0);
      drain("post_abort");
      for (int k = 0; k < W + 2; k++) begin
         @(negedge clk);
         chk($sformatf("no_stale_%0d", k), 32'(out_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Supports WIDTH-bit operands, a 4-bit opcode (original 8 ops plus shifts and an unsigned multiply), and a valid/ready handshake on both input and output.
- Single-cycle ops complete in 1 clock; multiply is iterative shift-add over WIDTH clocks.
- Sits between the datapath operand registers and the writeback stage.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is 2 to 32.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept a new operation
- op  in  4  operation select
- in_x  in  WIDTH  operand X
- in_y  in  WIDTH  operand Y
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- out_s  out  WIDTH  result
- out_c  out  1  carry / high-part flag
- zero  out  1  out_s == 0
- overflow  out  1  signed overflow

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0, in_ready=1.
  - out_s=0, out_c=0, zero=1, overflow=0.
  - Multiply counter and accumulator cleared.
  - Reset during MUL or DONE aborts the operation; no result is produced.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready at a rising edge; op, in_x and in_y are sampled only on accept.
- IDLE, non-multiply op accepted: result and flags registered on that edge; go to DONE. out_valid is visible the next cycle (latency 1).
- IDLE, op=1011 accepted:
  - Load multiplicand, multiplier, 2*WIDTH-bit accumulator=0, count=WIDTH; go to MUL.
- MUL:
  - Each cycle, if multiplier LSB=1, add multiplicand into the accumulator; shift multiplier right and multiplicand left; decrement count.
  - On the step where count==1, register the result and go to DONE.
  - out_valid is first high exactly WIDTH cycles after the accepting edge.
- DONE:
  - out_valid=1; outputs held stable.
  - On out_ready=1 at an edge, go to IDLE.
  - No new accept occurs in the same cycle as the drain; back-to-back throughput is one op per 2 cycles.
- in_valid while not ready is ignored. Input values may change freely and are not latched.
- Opcodes, all WIDTH-bit with wrap-around. zero = (out_s==0) for every op.
  - 0000 ADD: x+y. out_c = carry-out. overflow = signed overflow.
  - 0001 SUB: x+~y+1. out_c = carry-out (1 = no borrow). overflow = signed overflow.
  - 0010 NOT: ~x. out_c=0, overflow=0.
  - 0011 AND, 0100 OR, 0101 XOR: out_c=0, overflow=0.
  - 0110 SLT: out_s = {0…, sub_msb ^ sub_overflow}. out_c and overflow are taken from the subtraction.
  - 0111 EQ: out_s = {0…, (x==y)}. out_c and overflow are taken from the subtraction.
  - 1000 SLL: x << y. Shift amount = in_y as unsigned; amount >= WIDTH gives 0.
  - 1001 SRL: x >> y, same amount rule as SLL.
  - 1010 SRA: arithmetic right shift. Amount >= WIDTH gives all bits = x[MSB].
  - For all shifts: out_c=0, overflow=0.
  - 1011 MUL (unsigned): out_s = product[WIDTH-1:0]; out_c = |product[2W-1:W]; overflow=0.
  - 1100–1111 reserved: out_s=0, out_c=0, zero=1, overflow=0, 1-cycle latency.

Decomposition:
- Package alu_seq_pkg:
  - localparams for all 16 opcodes (OP_ADD … OP_MUL).
  - State encoding for IDLE/MUL/DONE.
- Sub-module: the team's existing adder, instantiated with N=WIDTH. It serves ADD, SUB, SLT and EQ and provides Carry/Zero/Overflow.
- The multiply accumulation uses its own 2*WIDTH-bit adder inline.

Test Plan (WIDTH=8):
- ADD x=0x7F, y=0x01 -> after 1 cycle: out_s=0x80, out_c=0, overflow=1, zero=0, out_valid=1.
- SUB x=0x05, y=0x05 -> out_s=0x00, zero=1, out_c=1. SLT x=0xFE(-2), y=0x01 -> out_s=0x01.
- SRA x=0x90, y=2 -> out_s=0xE4. SRL x=0x90, y=9 -> out_s=0x00. SLL x=0x81, y=1 -> out_s=0x02.
- MUL x=0x10, y=0x11 -> out_valid high exactly 8 cycles after accept; out_s=0x10, out_c=1. MUL 0x0F×0x0F -> 0xE1, out_c=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> outputs stable and in_ready=0; a new in_valid is ignored; raise out_ready -> IDLE next cycle.
- Assert rst at MUL cycle 4 -> immediately out_valid=0, in_ready=1, out_s=0. A subsequent ADD 3+4 returns 0x07 with no stale multiply result.
